// File: rtl/sram_req_arbiter.sv
// Two-master, one-slave arbiter for the SRAM-like bus: data port wins over instruction
// port, a grant locks until address acceptance, and a tag FIFO routes in-order responses back.
module sram_req_arbiter #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_INST = 2'd1,
      ARB_DATA = 2'd2
   } arb_state_e;

   arb_state_e       state_q, state_d;
   logic [DEPTH-1:0] tag_q, tag_d;
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;

   logic gnt_inst_s, gnt_data_s;
   logic full_s, empty_s, push_s, pop_s, head_s;

   assign full_s  = (count_q == CW'(DEPTH));
   assign empty_s = (count_q == {CW{1'b0}});
   assign head_s  = tag_q[rptr_q];

   // Select the granted master: combinational winner when idle, locked master otherwise.
   always_comb begin
      gnt_inst_s = 1'b0;
      gnt_data_s = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            gnt_data_s = data_req;
            gnt_inst_s = ~data_req & inst_req;
         end
         ARB_INST: gnt_inst_s = 1'b1;
         ARB_DATA: gnt_data_s = 1'b1;
         default: begin
            gnt_inst_s = 1'b0;
            gnt_data_s = 1'b0;
         end
      endcase
   end

   // Forward the granted master's request fields to the slave port.
   always_comb begin
      mem_req = resetn & ~full_s & ((gnt_inst_s & inst_req) | (gnt_data_s & data_req));
      if (gnt_data_s) begin
         mem_wr    = data_wr;
         mem_size  = data_size;
         mem_wstrb = data_wstrb;
         mem_addr  = data_addr;
         mem_wdata = data_wdata;
      end else begin
         mem_wr    = inst_wr;
         mem_size  = inst_size;
         mem_wstrb = inst_wstrb;
         mem_addr  = inst_addr;
         mem_wdata = inst_wdata;
      end
   end

   assign push_s = mem_req & mem_addr_ok;
   // A response only pops a tag that was pushed in an earlier cycle.
   assign pop_s  = resetn & mem_data_ok & ~empty_s;

   assign inst_addr_ok = push_s & gnt_inst_s;
   assign data_addr_ok = push_s & gnt_data_s;
   assign inst_data_ok = pop_s & ~head_s;
   assign data_data_ok = pop_s & head_s;
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   // Grant state transitions; a full FIFO freezes the grant.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: begin
            if (~full_s && (gnt_inst_s || gnt_data_s) && ~mem_addr_ok) begin
               state_d = gnt_data_s ? ARB_DATA : ARB_INST;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_INST, ARB_DATA: begin
            if (push_s) begin
               state_d = ARB_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Tag FIFO next-state: tag 1 marks a data-port transaction.
   always_comb begin
      tag_d  = tag_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push_s) begin
         tag_d[wptr_q] = gnt_data_s;
         wptr_d        = wptr_q + PW'(1);
      end else begin
         wptr_d = wptr_q;
      end
      if (pop_s) begin
         rptr_d = rptr_q + PW'(1);
      end else begin
         rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // State and FIFO registers with asynchronous clear.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ARB_IDLE;
         tag_q   <= {DEPTH{1'b0}};
         wptr_q  <= {PW{1'b0}};
         rptr_q  <= {PW{1'b0}};
         count_q <= {CW{1'b0}};
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter: a queue-based model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_sram_req_arbiter;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_wr;
   logic [1:0]  inst_size;
   logic [3:0]  inst_wstrb;
   logic [31:0] inst_addr, inst_wdata;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_addr_ok, mem_data_ok;
   logic [31:0] mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;
   bit run   = 1'b0;

   // model: origin queue of accepted transactions, and the locked master (-1 none, 0 I, 1 D)
   bit tagq[$];
   int lock_m = -1;

   sram_req_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int winner_f();
      if (lock_m >= 0) return lock_m;
      if (data_req) return 1;
      if (inst_req) return 0;
      return -1;
   endfunction

   function automatic bit exp_mem_req_f();
      int w = winner_f();
      if (!resetn || w < 0 || tagq.size() >= DEPTH) return 1'b0;
      return (w == 1) ? data_req : inst_req;
   endfunction

   // Model update on each clock edge; reset empties it immediately.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tagq.delete();
         lock_m = -1;
      end else begin
         int w;
         bit acc, was_full;
         w        = winner_f();
         acc      = exp_mem_req_f() && mem_addr_ok;
         was_full = (tagq.size() >= DEPTH);
         if (mem_data_ok && tagq.size() > 0) void'(tagq.pop_front());
         if (acc) tagq.push_back(w == 1);
         if (acc) lock_m = -1;
         else if (lock_m < 0 && w >= 0 && !was_full) lock_m = w;
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (run) begin
         int w;
         bit emr, has;
         w   = winner_f();
         emr = exp_mem_req_f();
         has = resetn && mem_data_ok && (tagq.size() > 0);
         chk1("m_mem_req", mem_req, emr);
         chk1("m_inst_addr_ok", inst_addr_ok, emr && mem_addr_ok && (w == 0));
         chk1("m_data_addr_ok", data_addr_ok, emr && mem_addr_ok && (w == 1));
         chk1("m_inst_data_ok", inst_data_ok, has && (tagq[0] == 1'b0));
         chk1("m_data_data_ok", data_data_ok, has && (tagq[0] == 1'b1));
         chk32("m_inst_rdata", inst_rdata, mem_rdata);
         chk32("m_data_rdata", data_rdata, mem_rdata);
         if (emr) begin
            chk32("m_mem_addr", mem_addr, (w == 1) ? data_addr : inst_addr);
            chk32("m_mem_wdata", mem_wdata, (w == 1) ? data_wdata : inst_wdata);
            chk1("m_mem_wr", mem_wr, (w == 1) ? data_wr : inst_wr);
            chk32("m_mem_size", {30'd0, mem_size}, {30'd0, (w == 1) ? data_size : inst_size});
            chk32("m_mem_wstrb", {28'd0, mem_wstrb}, {28'd0, (w == 1) ? data_wstrb : inst_wstrb});
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      inst_req = 1'b0; data_req = 1'b0;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn = 1'b0;
      idle_in();
      inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'h0; inst_addr = 32'h0; inst_wdata = 32'h0;
      data_wr = 1'b1; data_size = 2'd1; data_wstrb = 4'h3; data_addr = 32'h0; data_wdata = 32'hA5A5_0001;
      mem_rdata = 32'h0;
      #1;
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_inst_data_ok", inst_data_ok, 1'b0);
      cyc(); cyc();
      resetn = 1'b1;
      run = 1'b1;

      // single inst read
      inst_req = 1'b1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1'b1;
      #2;
      chk1("t1_inst_addr_ok", inst_addr_ok, 1'b1);
      chk32("t1_mem_addr", mem_addr, 32'h1C00_0000);
      cyc(); idle_in();
      #2 chk1("t1_no_data_ok", data_data_ok, 1'b0);
      cyc(); mem_data_ok = 1'b1; mem_rdata = 32'h0280_0C0C;
      #2;
      chk1("t1_inst_data_ok", inst_data_ok, 1'b1);
      chk32("t1_inst_rdata", inst_rdata, 32'h0280_0C0C);
      chk1("t1_data_data_ok", data_data_ok, 1'b0);
      cyc(); idle_in();

      // priority and lock
      data_req = 1'b1; data_addr = 32'h200; inst_req = 1'b1; inst_addr = 32'h100;
      #2;
      chk32("t2_mem_addr_c0", mem_addr, 32'h200);
      chk1("t2_data_addr_ok_c0", data_addr_ok, 1'b0);
      cyc(); cyc();
      #2 chk32("t2_mem_addr_c2", mem_addr, 32'h200);
      cyc(); mem_addr_ok = 1'b1;
      #2;
      chk1("t2_data_addr_ok_c3", data_addr_ok, 1'b1);
      chk1("t2_inst_addr_ok_c3", inst_addr_ok, 1'b0);
      cyc(); data_req = 1'b0;
      #2;
      chk1("t2_inst_addr_ok_c4", inst_addr_ok, 1'b1);
      chk32("t2_mem_addr_c4", mem_addr, 32'h100);
      cyc(); idle_in(); mem_data_ok = 1'b1; mem_rdata = 32'h1111_0000;
      #2 chk1("t2_resp_d", data_data_ok, 1'b1);
      cyc(); mem_rdata = 32'h2222_0000;
      #2 chk1("t2_resp_i", inst_data_ok, 1'b1);
      cyc(); idle_in();

      // out-of-origin ordering
      mem_addr_ok = 1'b1; inst_req = 1'b1; inst_addr = 32'h100;
      cyc(); inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h200;
      #2 chk1("t3_data_addr_ok", data_addr_ok, 1'b1);
      cyc(); data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h104;
      cyc(); idle_in(); mem_data_ok = 1'b1; mem_rdata = 32'hAAAA_0001;
      #2 chk1("t3_r0_inst", inst_data_ok, 1'b1);
      cyc(); mem_rdata = 32'hAAAA_0002;
      #2;
      chk1("t3_r1_data", data_data_ok, 1'b1);
      chk1("t3_r1_not_inst", inst_data_ok, 1'b0);
      cyc(); mem_rdata = 32'hAAAA_0003;
      #2 chk1("t3_r2_inst", inst_data_ok, 1'b1);
      cyc(); idle_in();

      // full
      inst_req = 1'b1; mem_addr_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         inst_addr = 32'h300 + 32'(4 * i);
         cyc();
      end
      inst_addr = 32'h310;
      #2;
      chk1("t4_full_mem_req", mem_req, 1'b0);
      chk1("t4_full_addr_ok", inst_addr_ok, 1'b0);
      cyc(); mem_data_ok = 1'b1;
      #2;
      chk1("t4_pop_cycle_mem_req", mem_req, 1'b0);
      chk1("t4_pop_inst_data_ok", inst_data_ok, 1'b1);
      cyc(); mem_data_ok = 1'b0;
      #2 chk1("t4_resume_addr_ok", inst_addr_ok, 1'b1);
      cyc(); idle_in(); mem_data_ok = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      idle_in();

      // same-cycle push and pop at count 2, then spurious response
      data_req = 1'b1; data_addr = 32'h400; mem_addr_ok = 1'b1;
      cyc(); data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h404;
      cyc(); inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h408; mem_data_ok = 1'b1;
      #2;
      chk1("t5_pushpop_data_ok", data_data_ok, 1'b1);
      chk1("t5_pushpop_addr_ok", data_addr_ok, 1'b1);
      cyc(); data_req = 1'b0;
      #2 chk1("t5_head_inst", inst_data_ok, 1'b1);
      cyc();
      #2 chk1("t5_head_data", data_data_ok, 1'b1);
      cyc();
      #2;
      chk1("t5_spurious_i", inst_data_ok, 1'b0);
      chk1("t5_spurious_d", data_data_ok, 1'b0);
      cyc(); idle_in();

      // reset mid-flight with 3 outstanding and I locked
      inst_req = 1'b1; mem_addr_ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         inst_addr = 32'h500 + 32'(4 * i);
         cyc();
      end
      inst_addr = 32'h50C; mem_addr_ok = 1'b0;
      cyc(); data_req = 1'b1; data_addr = 32'h600;
      #2 chk32("t6_locked_inst", mem_addr, 32'h50C);
      #1 resetn = 1'b0; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
      #1;
      chk1("t6_rst_mem_req", mem_req, 1'b0);
      chk1("t6_rst_inst_addr_ok", inst_addr_ok, 1'b0);
      chk1("t6_rst_data_addr_ok", data_addr_ok, 1'b0);
      chk1("t6_rst_inst_data_ok", inst_data_ok, 1'b0);
      chk1("t6_rst_data_data_ok", data_data_ok, 1'b0);
      cyc(); cyc();
      resetn = 1'b1; mem_addr_ok = 1'b0;
      #2;
      chk32("t6_idle_after_rst", mem_addr, 32'h600);
      chk1("t6_late_inst_drop", inst_data_ok, 1'b0);
      chk1("t6_late_data_drop", data_data_ok, 1'b0);
      cyc(); mem_data_ok = 1'b0; mem_addr_ok = 1'b1;
      #2 chk1("t6_d_accept", data_addr_ok, 1'b1);
      cyc(); data_req = 1'b0;
      #2 chk1("t6_i_accept", inst_addr_ok, 1'b1);
      cyc(); idle_in(); mem_data_ok = 1'b1;
      #2 chk1("t6_resp_d", data_data_ok, 1'b1);
      cyc();
      #2 chk1("t6_resp_i", inst_data_ok, 1'b1);
      cyc(); idle_in();
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
